emu_time_manager: RTL

- Central responder for the emulator timestep protocol. Every oscillator or timed model drives a dt request. This block collects those requests and broadcasts the granted emu_dt, which is the minimum active request.
- A model fires when the granted emu_dt equals its own request.
- The block owns the absolute emulation time. It also provides host-side run control: stop, free-run, run N steps, and run until a target time.

---
 rtl/emu_time_manager_pkg.sv | 24 ++
 rtl/emu_time_manager_if.sv | 28 ++
 rtl/emu_dt_min_tree.sv | 39 +++
 rtl/emu_time_manager.sv | 125 ++++++++++++
 4 files changed

// File: rtl/emu_time_manager_pkg.sv
// emu_time_manager: shared types for the emulation time manager.
// State and command encodings used by the FSM and host control port.
package emu_tm_pkg;

  localparam logic [1:0] MODE_STOP  = 2'd0;
  localparam logic [1:0] MODE_RUN   = 2'd1;
  localparam logic [1:0] MODE_STEP  = 2'd2;
  localparam logic [1:0] MODE_UNTIL = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_STEP  = 2'd2,
    ST_UNTIL = 2'd3
  } tm_state_t;

  typedef enum logic [1:0] {
    M_STOP  = MODE_STOP,
    M_RUN   = MODE_RUN,
    M_STEP  = MODE_STEP,
    M_UNTIL = MODE_UNTIL
  } tm_mode_t;

endpackage

// File: rtl/emu_time_manager_if.sv
// emu_time_manager_if: host run-control command channel.
// Host is master; the time manager is slave and always ready.
interface emu_time_manager_if #(
  parameter int STEP_WIDTH = 32,
  parameter int TIME_WIDTH = 64
);
  logic                  ctrl_valid;
  logic                  ctrl_ready;
  logic [1:0]            ctrl_mode;
  logic [STEP_WIDTH-1:0] ctrl_steps;
  logic [TIME_WIDTH-1:0] ctrl_stop_time;

  modport master (
    output ctrl_valid,
    output ctrl_mode,
    output ctrl_steps,
    output ctrl_stop_time,
    input  ctrl_ready
  );

  modport slave (
    input  ctrl_valid,
    input  ctrl_mode,
    input  ctrl_steps,
    input  ctrl_stop_time,
    output ctrl_ready
  );
endinterface

// File: rtl/emu_dt_min_tree.sv
// emu_dt_min_tree: masked minimum of the dt requests.
// Balanced pairwise tree; disabled or padding leaves read as all-ones.
module emu_dt_min_tree #(
  parameter int N_REQ    = 4,
  parameter int DT_WIDTH = 27
) (
  input  logic [N_REQ*DT_WIDTH-1:0] req_i,
  input  logic [N_REQ-1:0]          en_i,
  output logic [DT_WIDTH-1:0]       dt_min_o
);

  localparam int L = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int P = 1 << L;

  for (genvar lv = 0; lv <= L; lv++) begin : g_lvl
    localparam int W = P >> lv;
    logic [DT_WIDTH-1:0] v [W];
    if (lv == 0) begin : g_leaf
      for (genvar i = 0; i < W; i++) begin : g_in
        if (i < N_REQ) begin : g_used
          assign v[i] = en_i[i] ? req_i[i*DT_WIDTH +: DT_WIDTH] : '1;
        end else begin : g_pad
          assign v[i] = '1;
        end
      end
    end else begin : g_node
      for (genvar j = 0; j < W; j++) begin : g_cmp
        logic [DT_WIDTH-1:0] a;
        logic [DT_WIDTH-1:0] b;
        assign a    = g_lvl[lv-1].v[2*j];
        assign b    = g_lvl[lv-1].v[2*j+1];
        assign v[j] = (a <= b) ? a : b;
      end
    end
  end

  assign dt_min_o = g_lvl[L].v[0];

endmodule

// File: rtl/emu_time_manager.sv
// emu_time_manager: grants the global timestep and owns emulation time.
// Host commands select stop, free-run, N-step or run-until-time.
module emu_time_manager
  import emu_tm_pkg::*;
#(
  parameter int N_REQ      = 4,
  parameter int DT_WIDTH   = 27,
  parameter int TIME_WIDTH = 64,
  parameter int STEP_WIDTH = 32
) (
  input  logic                      emu_clk,
  input  logic                      emu_rst,
  input  logic [N_REQ*DT_WIDTH-1:0] emu_dt_req,
  input  logic [N_REQ-1:0]          req_en,
  output logic [DT_WIDTH-1:0]       emu_dt,
  output logic [TIME_WIDTH-1:0]     emu_time,
  emu_time_manager_if.slave         ctrl,
  output logic [1:0]                state,
  output logic                      done
);

  localparam logic [TIME_WIDTH-1:0] DT_MAX_T =
    TIME_WIDTH'({DT_WIDTH{1'b1}});

  tm_state_t             state_q, state_d;
  logic [TIME_WIDTH-1:0] time_q, time_d;
  logic [STEP_WIDTH-1:0] steps_q, steps_d;
  logic [TIME_WIDTH-1:0] stop_q, stop_d;
  logic                  done_q, done_d;

  logic [DT_WIDTH-1:0]   dt_min;
  logic [DT_WIDTH-1:0]   rem;
  logic [TIME_WIDTH-1:0] diff;
  logic                  past_stop;

  emu_dt_min_tree #(
    .N_REQ    (N_REQ),
    .DT_WIDTH (DT_WIDTH)
  ) u_min (
    .req_i    (emu_dt_req),
    .en_i     (req_en),
    .dt_min_o (dt_min)
  );

  assign ctrl.ctrl_ready = 1'b1;
  assign emu_time        = time_q;
  assign state           = state_q;
  assign done            = done_q;

  // distance to target, clamped to what one dt can express
  assign past_stop = (stop_q <= time_q);
  assign diff      = stop_q - time_q;
  assign rem       = past_stop ? '0 :
                     (diff > DT_MAX_T) ? '1 : diff[DT_WIDTH-1:0];

  always_comb begin
    emu_dt = '0;
    unique case (state_q)
      ST_IDLE:  emu_dt = '0;
      ST_RUN:   emu_dt = dt_min;
      ST_STEP:  emu_dt = (steps_q != '0) ? dt_min : '0;
      ST_UNTIL: emu_dt = (dt_min <= rem) ? dt_min : rem;
    endcase
  end

  always_comb begin
    state_d = state_q;
    steps_d = steps_q;
    stop_d  = stop_q;
    done_d  = 1'b0;
    time_d  = time_q + TIME_WIDTH'(emu_dt);

    if (state_q == ST_STEP) begin
      if (steps_q == '0) begin
        state_d = ST_IDLE;
        done_d  = 1'b1;
      end else if (emu_dt != '0) begin
        steps_d = steps_q - STEP_WIDTH'(1);
        if (steps_q == STEP_WIDTH'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
    end

    if (state_q == ST_UNTIL && (past_stop || time_d == stop_q)) begin
      state_d = ST_IDLE;
      done_d  = 1'b1;
    end

    // a new command preempts any completion in the same cycle
    if (ctrl.ctrl_valid) begin
      done_d = 1'b0;
      unique case (tm_mode_t'(ctrl.ctrl_mode))
        M_STOP:  state_d = ST_IDLE;
        M_RUN:   state_d = ST_RUN;
        M_STEP: begin
          state_d = ST_STEP;
          steps_d = ctrl.ctrl_steps;
        end
        M_UNTIL: begin
          state_d = ST_UNTIL;
          stop_d  = ctrl.ctrl_stop_time;
        end
      endcase
    end
  end

  always_ff @(posedge emu_clk) begin
    if (!emu_rst) begin
      state_q <= ST_IDLE;
      time_q  <= '0;
      steps_q <= '0;
      stop_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      time_q  <= time_d;
      steps_q <= steps_d;
      stop_q  <= stop_d;
      done_q  <= done_d;
    end
  end

endmodule
